// File: rtl/cfg_chain_pkg.sv
// Shared types and constants for the pipelined generate/propagate/kill carry chain.
package cfg_chain_pkg;

    localparam int unsigned CFG_G0      = 0;
    localparam int unsigned CFG_G1      = 1;
    localparam int unsigned CFG_K0      = 2;
    localparam int unsigned CFG_K1      = 3;
    localparam int unsigned CFG_W       = 4;
    // Widest chain the stage payload can carry; narrower chains leave upper bits at zero.
    localparam int unsigned CHAIN_MAX_W = 64;

    typedef struct packed {
        logic                   valid;
        logic                   carry;
        logic [CHAIN_MAX_W-1:0] sum;
        logic                   prop;
        logic [CHAIN_MAX_W-1:0] d;
        logic [CHAIN_MAX_W-1:0] s;
        logic [CFG_W-1:0]       cfg;
    } stage_t;

    function automatic int unsigned seg_width(input int unsigned w, input int unsigned stages);
        return (w + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/cfg_chain_seg.sv
// Combinational G/K/P terms and carry ripple for one contiguous segment of slices.
module cfg_chain_seg
    import cfg_chain_pkg::*;
#(
    parameter int unsigned SW = 1
) (
    input  logic [SW-1:0]    d_i,
    input  logic [SW-1:0]    s_i,
    input  logic [CFG_W-1:0] cfg_i,
    input  logic             cin_i,
    output logic [SW-1:0]    sum_c_o,
    output logic             cout_c_o,
    output logic             prop_c_o
);

    logic [SW-1:0] g_c;
    logic [SW-1:0] k_c;
    logic [SW-1:0] p_c;
    logic [SW:0]   c_c;

    // Ripple kept in one process so the carry vector is not a self-referencing net.
    always_comb begin
        g_c    = '0;
        k_c    = '0;
        p_c    = '0;
        c_c    = '0;
        c_c[0] = cin_i;
        for (int i = 0; i < int'(SW); i++) begin
            g_c[i]   = d_i[i] & (s_i[i] ? ~cfg_i[CFG_G1] : cfg_i[CFG_G0]);
            k_c[i]   = ~d_i[i] & ~(s_i[i] ? cfg_i[CFG_K1] : cfg_i[CFG_K0]);
            p_c[i]   = ~g_c[i] & ~k_c[i];
            c_c[i+1] = g_c[i] | (p_c[i] & c_c[i]);
        end
    end

    assign sum_c_o  = p_c ^ c_c[SW-1:0];
    assign cout_c_o = c_c[SW];
    assign prop_c_o = &p_c;

endmodule

// File: rtl/cfg_carry_chain_pipe.sv
// Pipelined configurable carry chain with valid/ready handshake and carry accumulate mode.
module cfg_carry_chain_pipe
    import cfg_chain_pkg::*;
#(
    parameter int unsigned W      = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     d_i,
    input  logic [W-1:0]     s_i,
    input  logic [CFG_W-1:0] cfg_i,
    input  logic             cin_i,
    input  logic             acc_en_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     sum_o,
    output logic             cout_o,
    output logic             all_prop_o
);

    localparam int unsigned SEG  = seg_width(W, STAGES);
    localparam int unsigned LAST = STAGES - 1;
    localparam int unsigned IW   = $clog2(STAGES + 1);

    stage_t [STAGES-1:0] stage_q;
    stage_t [STAGES-1:0] stage_d;
    stage_t              src0_c;
    logic [IW-1:0]       inflight_q;
    logic [IW-1:0]       inflight_d;
    logic                carry_q;
    logic                carry_d;
    logic                advance_c;
    logic                out_hs_c;
    logic                accept_c;
    logic                c0_c;
    logic                unused_c;

    assign advance_c = ~stage_q[LAST].valid | out_ready_i;
    assign out_hs_c  = stage_q[LAST].valid & out_ready_i;
    assign accept_c  = in_valid_i & in_ready_o;

    // An accumulate beat may only enter when it is the sole beat it depends on.
    assign in_ready_o = advance_c &
                        ~(acc_en_i & in_valid_i & (inflight_q != '0) &
                          ~((inflight_q == IW'(1)) & out_hs_c));

    // Forward the departing cout so a beat accepted on that handshake sees it.
    assign carry_d = out_hs_c ? stage_q[LAST].carry : carry_q;
    assign c0_c    = acc_en_i ? carry_d : cin_i;

    always_comb begin
        src0_c       = '0;
        src0_c.valid = accept_c;
        src0_c.carry = c0_c;
        src0_c.prop  = 1'b1;
        src0_c.d     = CHAIN_MAX_W'(d_i);
        src0_c.s     = CHAIN_MAX_W'(s_i);
        src0_c.cfg   = cfg_i;
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({accept_c, out_hs_c})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    for (genvar j = 0; j < int'(STAGES); j++) begin : g_stage
        localparam int unsigned LO = j * SEG;
        localparam int unsigned SW = (LO >= W) ? 0 : (((W - LO) < SEG) ? (W - LO) : SEG);

        stage_t src_c;
        stage_t nxt_c;

        if (j == 0) begin : g_src_in
            assign src_c = src0_c;
        end else begin : g_src_reg
            assign src_c = stage_q[j-1];
        end

        if (SW > 0) begin : g_seg
            logic [SW-1:0] seg_sum_c;
            logic          seg_cout_c;
            logic          seg_prop_c;

            cfg_chain_seg #(.SW(SW)) u_seg (
                .d_i      (src_c.d[LO +: SW]),
                .s_i      (src_c.s[LO +: SW]),
                .cfg_i    (src_c.cfg),
                .cin_i    (src_c.carry),
                .sum_c_o  (seg_sum_c),
                .cout_c_o (seg_cout_c),
                .prop_c_o (seg_prop_c)
            );

            always_comb begin
                nxt_c                = src_c;
                nxt_c.sum[LO +: SW]  = seg_sum_c;
                nxt_c.carry          = seg_cout_c;
                nxt_c.prop           = src_c.prop & seg_prop_c;
            end
        end else begin : g_pass
            // Short chains can leave trailing stages with no slices; they only delay.
            assign nxt_c = src_c;
        end

        assign stage_d[j] = nxt_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q    <= '0;
            inflight_q <= '0;
            carry_q    <= 1'b0;
        end else begin
            if (advance_c) begin
                stage_q <= stage_d;
            end
            inflight_q <= inflight_d;
            carry_q    <= carry_d;
        end
    end

    assign out_valid_o = stage_q[LAST].valid;
    assign sum_o       = stage_q[LAST].sum[W-1:0];
    assign cout_o      = stage_q[LAST].carry;
    assign all_prop_o  = stage_q[LAST].prop;

    // Payload bits beyond W and the last stage's operands have no consumer.
    assign unused_c = ^stage_q;

endmodule
